// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Bundles the request and result signals of the HI/LO multiply/divide unit.
//   master : control path (drives start/op/a/b, reads busy/done/div_by_zero/hi/lo)
//   slave  : muldiv_sequencer
//
// Handshake: start is a request qualified by busy. The unit samples start/op/a/b
// only on a clock edge where busy=0; a request presented while busy=1 is dropped,
// not queued. done is a one-cycle pulse marking the first cycle in which hi/lo
// hold the new result, and start may be raised in that same cycle.
// div_by_zero is meaningful only while done=1.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative HI/LO unit: MULT/MULTU (shift-add) and DIV/DIVU (restoring),
//   one radix-2 step per cycle on operand magnitudes, then one sign-fixup
//   cycle that writes HI/LO. MTHI/MTLO write HI/LO directly from IDLE.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high; clears all state and aborts any op
//   bus       muldiv_sequencer_if.slave (start/op/a/b in, busy/done/
//             div_by_zero/hi/lo out)
//   dbg_state current FSM state (0 IDLE, 1 RUN, 2 FIX) for observation
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  muldiv_sequencer_if.slave    bus,
  output logic [1:0]           dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] acc;        // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   orig_a;     // raw dividend, returned in HI on divide by zero
  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_res;    // product/quotient sign
  logic               neg_rem;    // remainder takes the dividend's sign
  logic               b_zero;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q;

  // Request decode and operand magnitudes (op[0]=0 means signed variant).
  logic             iter_req, mthi_req, mtlo_req;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign iter_req = bus.start && (bus.op[2] == 1'b0);
  assign mthi_req = bus.start && (bus.op == 3'b100);
  assign mtlo_req = bus.start && (bus.op == 3'b101);
  assign a_neg    = ~bus.op[0] & bus.a[WIDTH-1];
  assign b_neg    = ~bus.op[0] & bus.b[WIDTH-1];
  assign mag_a    = a_neg ? -bus.a : bus.a;
  assign mag_b    = b_neg ? -bus.b : bus.b;

  // Multiply step: add multiplicand to the upper half when the multiplier LSB
  // is set, then shift the whole accumulator right (carry enters at the top).
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder,
  // keep the difference when it is non-negative, and shift in the quotient bit.
  logic [WIDTH:0]     rem_sh, diff;
  logic               fits;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, opnd};
  assign fits     = ~diff[WIDTH];
  assign div_next = {(fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], fits};

  // Sign fixup values used in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iter_req) state_next = RUN;
      RUN:     if (count == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      opnd    <= '0;
      orig_a  <= '0;
      count   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (iter_req) begin
            is_div  <= bus.op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (bus.b == '0);
            orig_a  <= bus.a;
            count   <= '0;
            opnd    <= bus.op[1] ? mag_b : mag_a;
            acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
          end else if (mthi_req) begin
            hi_q   <= bus.a;
            done_q <= 1'b1;
          end else if (mtlo_req) begin
            lo_q   <= bus.a;
            done_q <= 1'b1;
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 1'b1;
        end
        FIX: begin
          done_q <= 1'b1;
          if (!is_div) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (b_zero) begin
            hi_q <= orig_a;
            lo_q <= '1;
            dz_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed-vector bench for muldiv_sequencer: reset state, signed/unsigned
//   multiply and divide, divide by zero, MTHI/MTLO, ignored ops, back-to-back
//   issue, start-while-busy and abort by reset.
module tb_muldiv_sequencer;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) mdif ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (mdif.slave),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- driver tasks ----------------
  // Every task returns 1 time unit after a rising edge, so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one iterative op and wait (bounded) for done.
  // lat: cycle index of done where the cycle after the start edge is 1 (-1 on timeout).
  // busy_n: number of cycles busy was high before done.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n);
    mdif.start = 1'b1;
    mdif.op    = op;
    mdif.a     = a;
    mdif.b     = b;
    tick();
    // Operands may change freely once the op is running.
    mdif.start = 1'b0;
    mdif.a     = ~a;
    mdif.b     = ~b;
    lat    = -1;
    busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (mdif.busy) busy_n++;
      if (mdif.done) begin
        lat = i;
        break;
      end
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (mdif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", mdif.busy); end
    total++; if (mdif.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", mdif.done); end
    total++; if (mdif.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", mdif.div_by_zero); end
    total++; if (mdif.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=00000000", mdif.hi); end
    total++; if (mdif.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=00000000", mdif.lo); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_mult_signed();
    int lat, bn;
    run_op(3'b000, 32'hFFFF_FFFD, 32'd7, lat, bn);
    total++; if (lat !== 34) begin bad++; $display("FAIL mult_latency got=%0d exp=34", lat); end
    total++; if (bn !== 33) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=33", bn); end
    total++; if (mdif.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", mdif.hi); end
    total++; if (mdif.lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo got=%h exp=ffffffeb", mdif.lo); end
    total++; if (mdif.div_by_zero !== 1'b0) begin bad++; $display("FAIL mult_dz got=%b exp=0", mdif.div_by_zero); end
    total++; if (mdif.busy !== 1'b0) begin bad++; $display("FAIL mult_busy_at_done got=%b exp=0", mdif.busy); end
    tick();
    total++; if (mdif.done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b exp=0", mdif.done); end
  endtask

  task automatic test_mult_unsigned();
    int lat, bn;
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn);
    total++; if (lat !== 34) begin bad++; $display("FAIL multu_latency got=%0d exp=34", lat); end
    total++; if (mdif.hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", mdif.hi); end
    total++; if (mdif.lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", mdif.lo); end
    tick();
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn);
    total++; if (mdif.hi !== 32'h0) begin bad++; $display("FAIL mult_m1_hi got=%h exp=00000000", mdif.hi); end
    total++; if (mdif.lo !== 32'h1) begin bad++; $display("FAIL mult_m1_lo got=%h exp=00000001", mdif.lo); end
  endtask

  task automatic test_div();
    int lat, bn;
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, lat, bn);
    total++; if (lat !== 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", lat); end
    total++; if (mdif.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_lo got=%h exp=fffffffd", mdif.lo); end
    total++; if (mdif.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_hi got=%h exp=ffffffff", mdif.hi); end
    tick();
    run_op(3'b011, 32'd100, 32'd7, lat, bn);
    total++; if (mdif.lo !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h exp=0000000e", mdif.lo); end
    total++; if (mdif.hi !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h exp=00000002", mdif.hi); end
    tick();
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn);
    total++; if (mdif.lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", mdif.lo); end
    total++; if (mdif.hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi got=%h exp=00000000", mdif.hi); end
    total++; if (mdif.div_by_zero !== 1'b0) begin bad++; $display("FAIL div_ovf_dz got=%b exp=0", mdif.div_by_zero); end
  endtask

  task automatic test_div_by_zero();
    int lat, bn;
    run_op(3'b011, 32'd100, 32'd0, lat, bn);
    total++; if (lat !== 34) begin bad++; $display("FAIL dbz_latency got=%0d exp=34", lat); end
    total++; if (mdif.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", mdif.div_by_zero); end
    total++; if (mdif.hi !== 32'd100) begin bad++; $display("FAIL dbz_hi got=%h exp=00000064", mdif.hi); end
    total++; if (mdif.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dbz_lo got=%h exp=ffffffff", mdif.lo); end
    tick();
    total++; if (mdif.div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_flag_clear got=%b exp=0", mdif.div_by_zero); end
    run_op(3'b000, 32'd5, 32'd6, lat, bn);
    total++; if (mdif.div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_next_mult_dz got=%b exp=0", mdif.div_by_zero); end
    total++; if (mdif.lo !== 32'd30) begin bad++; $display("FAIL dbz_next_mult_lo got=%h exp=0000001e", mdif.lo); end
    total++; if (mdif.hi !== 32'd0) begin bad++; $display("FAIL dbz_next_mult_hi got=%h exp=00000000", mdif.hi); end
    tick();
  endtask

  // Expects hi=0, lo=30 from the preceding test.
  task automatic test_mthi_mtlo();
    mdif.start = 1'b1;
    mdif.op    = 3'b100;
    mdif.a     = 32'h1234_5678;
    tick();
    total++; if (mdif.hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi_hi got=%h exp=12345678", mdif.hi); end
    total++; if (mdif.lo !== 32'd30) begin bad++; $display("FAIL mthi_lo_kept got=%h exp=0000001e", mdif.lo); end
    total++; if (mdif.busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b exp=0", mdif.busy); end
    total++; if (mdif.done !== 1'b1) begin bad++; $display("FAIL mthi_done got=%b exp=1", mdif.done); end
    mdif.op = 3'b101;
    mdif.a  = 32'hCAFE_BABE;
    tick();
    total++; if (mdif.lo !== 32'hCAFE_BABE) begin bad++; $display("FAIL mtlo_lo got=%h exp=cafebabe", mdif.lo); end
    total++; if (mdif.hi !== 32'h1234_5678) begin bad++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", mdif.hi); end
    total++; if (mdif.done !== 1'b1) begin bad++; $display("FAIL mtlo_done got=%b exp=1", mdif.done); end
    mdif.op = 3'b110;
    mdif.a  = 32'hFFFF_FFFF;
    tick();
    mdif.start = 1'b0;
    total++; if (mdif.done !== 1'b0) begin bad++; $display("FAIL op110_done got=%b exp=0", mdif.done); end
    total++; if (mdif.busy !== 1'b0) begin bad++; $display("FAIL op110_busy got=%b exp=0", mdif.busy); end
    total++; if (mdif.hi !== 32'h1234_5678) begin bad++; $display("FAIL op110_hi got=%h exp=12345678", mdif.hi); end
    total++; if (mdif.lo !== 32'hCAFE_BABE) begin bad++; $display("FAIL op110_lo got=%h exp=cafebabe", mdif.lo); end
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    run_op(3'b011, 32'd100, 32'd7, lat, bn);
    // run_op returns in the done cycle; the next request starts right here.
    run_op(3'b001, 32'd3, 32'd4, lat, bn);
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
    total++; if (mdif.lo !== 32'd12) begin bad++; $display("FAIL b2b_lo got=%h exp=0000000c", mdif.lo); end
    total++; if (mdif.hi !== 32'd0) begin bad++; $display("FAIL b2b_hi got=%h exp=00000000", mdif.hi); end
    tick();
  endtask

  task automatic test_ignore_and_abort();
    int lat;
    int dones;
    // MULT 0x10 * 0x20 with an MTHI request while busy.
    mdif.start = 1'b1; mdif.op = 3'b000; mdif.a = 32'h10; mdif.b = 32'h20;
    tick();
    mdif.start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    mdif.start = 1'b1; mdif.op = 3'b100; mdif.a = 32'hDEAD_BEEF;
    tick();
    mdif.start = 1'b0;
    lat = -1;
    for (int i = 11; i <= 40; i++) begin
      if (mdif.done) begin
        lat = i;
        break;
      end
      tick();
    end
    total++; if (lat !== 34) begin bad++; $display("FAIL ignore_latency got=%0d exp=34", lat); end
    total++; if (mdif.hi !== 32'h0) begin bad++; $display("FAIL ignore_hi got=%h exp=00000000", mdif.hi); end
    total++; if (mdif.lo !== 32'h200) begin bad++; $display("FAIL ignore_lo got=%h exp=00000200", mdif.lo); end
    tick();
    // Abort a running MULT with reset.
    mdif.start = 1'b1; mdif.op = 3'b000; mdif.a = 32'd3; mdif.b = 32'd4;
    tick();
    mdif.start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (mdif.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", mdif.busy); end
    total++; if (mdif.hi !== 32'h0) begin bad++; $display("FAIL abort_hi got=%h exp=00000000", mdif.hi); end
    total++; if (mdif.lo !== 32'h0) begin bad++; $display("FAIL abort_lo got=%h exp=00000000", mdif.lo); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (mdif.done) dones++;
      tick();
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    total++; if (mdif.lo !== 32'h0) begin bad++; $display("FAIL abort_lo_after got=%h exp=00000000", mdif.lo); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    mdif.start = 1'b0;
    mdif.op    = 3'b000;
    mdif.a     = '0;
    mdif.b     = '0;
    tick();
    test_reset();
    test_mult_signed();
    test_mult_unsigned();
    test_div();
    test_div_by_zero();
    test_mthi_mtlo();
    test_back_to_back();
    test_ignore_and_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle HI/LO multiply/divide unit alongside the single-cycle ALU; executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO directly.
- Owns the HI and LO registers and raises busy so the control path can stall the PC and hold the instruction.
- One radix-2 step per cycle (shift-add multiply, restoring divide) on operand magnitudes, followed by a sign-fixup cycle.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  request, sampled only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored
a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
b  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  operation in progress; the control path stalls while high
done  output  1  one-cycle pulse when hi/lo hold a new result
div_by_zero  output  1  valid only when done=1; set for DIV/DIVU with b=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (reset); polarity and synchronicity are fixed.
- Reset values: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, iteration counter=0. Reset takes priority over start and aborts any operation in progress. No partial result reaches hi/lo.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU (edge E0):
  - Latch operand magnitudes. Signed ops take the absolute value; unsigned ops use raw values.
  - Latch the result-sign bits and a signed/unsigned flag. Clear the counter.
  - Go to RUN; busy=1 from the cycle after E0.
- RUN: one iteration per edge. The counter counts 0..WIDTH-1. After WIDTH edges (E1..E32 for WIDTH=32), go to FIX.
- Multiply datapath: 2*WIDTH-bit accumulator, shift-add of the multiplicand magnitude on the multiplier LSB.
- Divide datapath: restoring. Remainder is shifted left with the next dividend bit; subtract the divisor when it fits; the quotient bit is 1 when the subtract succeeded.
- FIX (E33) applies sign fixup and writes the result:
  - Signed multiply: if the operand signs differ, the 64-bit product is two's-complement negated; hi=upper half, lo=lower half.
  - Signed divide: lo=quotient, negated if the operand signs differ; hi=remainder, taking the dividend's sign.
- Cycle after E33: done=1, busy=0, state=IDLE. The full result is visible 34 cycles after the start cycle when WIDTH=32.
- Divide by zero (b=0, DIV or DIVU): runs the full latency; result hi=a (original value), lo={WIDTH{1}}, div_by_zero=1 with done.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0, div_by_zero=0.
- MTHI/MTLO with start=1 in IDLE: hi (or lo) <= a at E0. The other register is unchanged. busy stays 0; done=1 in the next cycle.
- op 110/111: no state change and no done.
- start while busy=1 is ignored; operands may change freely during RUN.
- done is never high for more than one cycle. start=1 in the done cycle is accepted, so back-to-back operations are allowed.
- hi/lo hold their values between operations and are read combinationally (mfhi/mflo).

Test Plan:
- reset 1 cycle; MULT a=0xFFFFFFFD (-3), b=7 -> busy for 33 cycles, done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_by_zero=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> done at cycle 34 with div_by_zero=1, hi=100, lo=0xFFFFFFFF. The next MULT completes with div_by_zero=0.
- MULT started; start=1 with op=MTHI at cycle 10 -> ignored, hi/lo match the MULT result only. Assert reset at cycle 20 -> next cycle busy=0, hi=lo=0, no done pulse.
- MTHI a=0x12345678 -> hi=0x12345678 after the edge, lo unchanged, busy=0, done=1 next cycle. Then immediately MTLO a=0xCAFEBABE -> lo updated.
